// File: rtl/atm_input_cond.sv
// atm_input_cond: input conditioning for the ATM front panel.
// Three push buttons and a 4-bit switch bank are synchronised and debounced.
// Buttons become single-cycle press pulses (one at a time, BTN1 > BTN2 > BTN3),
// and the switch bank becomes a debounced 4-bit value that never changes while
// a press pulse is being issued.
module atm_input_cond #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BTN3_raw,
    input  logic       BTN2_raw,
    input  logic       BTN1_raw,
    input  logic [3:0] SW_raw,
    output logic       BTN3,
    output logic       BTN2,
    output logic       BTN1,
    output logic [3:0] SW
);

    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    // Button bit order everywhere below: [0]=BTN1, [1]=BTN2, [2]=BTN3.
    logic [2:0]    btn_ff1;
    logic [2:0]    btn_ff2;
    logic [3:0]    sw_ff1;
    logic [3:0]    sw_ff2;

    logic [2:0]    btn_stable;
    logic [CW-1:0] btn_cnt [3];
    logic [2:0]    btn_accept;
    logic [2:0]    btn_rise;
    logic [2:0]    pulse_nxt;

    logic [3:0]    sw_last;
    logic [CW-1:0] sw_cnt;
    logic [CW-1:0] sw_base;
    logic          sw_due;

    // Two-flop synchronisers on every raw input bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_ff1 <= '0;
            btn_ff2 <= '0;
            sw_ff1  <= '0;
            sw_ff2  <= '0;
        end else begin
            btn_ff1 <= {BTN3_raw, BTN2_raw, BTN1_raw};
            btn_ff2 <= btn_ff1;
            sw_ff1  <= SW_raw;
            sw_ff2  <= sw_ff1;
        end
    end

    // Acceptance and rising-edge detection per button, then fixed priority.
    always_comb begin
        btn_accept = '0;
        btn_rise   = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            btn_accept[i] = (btn_ff2[i] != btn_stable[i]) && (btn_cnt[i] == CNT_MAX);
            btn_rise[i]   = btn_accept[i] & btn_ff2[i];
        end
        pulse_nxt[0] = btn_rise[0];
        pulse_nxt[1] = btn_rise[1] & ~btn_rise[0];
        pulse_nxt[2] = btn_rise[2] & ~btn_rise[1] & ~btn_rise[0];
    end

    // Per-button debounce: count consecutive cycles the synced value differs from stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_stable <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                btn_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (btn_ff2[i] == btn_stable[i]) begin
                    btn_cnt[i] <= '0;
                end else if (btn_accept[i]) begin
                    btn_stable[i] <= btn_ff2[i];
                    btn_cnt[i]    <= '0;
                end else begin
                    btn_cnt[i] <= btn_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Registered press pulses; losing buttons in a tie are simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            BTN1 <= 1'b0;
            BTN2 <= 1'b0;
            BTN3 <= 1'b0;
        end else begin
            BTN1 <= pulse_nxt[0];
            BTN2 <= pulse_nxt[1];
            BTN3 <= pulse_nxt[2];
        end
    end

    // A new synced vector restarts the count as if it were the first deviating
    // cycle, so every candidate value must hold for DB_CYCLES synced cycles.
    always_comb begin
        sw_base = (sw_ff2 != sw_last) ? '0 : sw_cnt;
        sw_due  = (sw_ff2 != SW) && (sw_base == CNT_MAX);
    end

    // Group debounce of the switch bank; an acceptance that lands on a press
    // pulse is held at the terminal count and taken on the following edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            SW      <= '0;
            sw_cnt  <= '0;
            sw_last <= '0;
        end else begin
            sw_last <= sw_ff2;
            if (sw_ff2 == SW) begin
                sw_cnt <= '0;
            end else if (sw_due) begin
                if (|pulse_nxt) begin
                    sw_cnt <= sw_base;
                end else begin
                    SW     <= sw_ff2;
                    sw_cnt <= '0;
                end
            end else begin
                sw_cnt <= sw_base + 1'b1;
            end
        end
    end

endmodule
